wb_regfile_stage: RTL and testbench

- Write-back end of the MEM/WB pipeline interface.
- Consumes the registered MEM/WB outputs: rt/rd fields, memory read data, ALU result, next-PC and the 5-bit control bundle.
- Selects the destination register and write data, and commits to a 32x32 register file.
- Serves the ID-stage read ports with write-before-read bypass and exports the WB forwarding triple to the hazard unit.

---
 rtl/mips_pkg.sv | 27 ++
 rtl/regfile_2r1w.sv | 54 +++++
 rtl/wb_regfile_stage.sv | 95 +++++++++
 tb/tb_wb_regfile_stage.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Shared MIPS pipeline constants: control-bundle layout, RegDst/MemtoReg codes
// and the fixed register numbers used by decode and write-back.
package mips_pkg;

  localparam int CTRL_WIDTH     = 5;
  localparam int CTRL_REGDST_HI = 4;
  localparam int CTRL_REGDST_LO = 3;
  localparam int CTRL_WBSEL_HI  = 2;
  localparam int CTRL_WBSEL_LO  = 1;
  localparam int CTRL_REGWRITE  = 0;

  typedef enum logic [1:0] {
    REGDST_RT   = 2'b00,
    REGDST_RD   = 2'b01,
    REGDST_LINK = 2'b10
  } regdst_e;

  typedef enum logic [1:0] {
    WBSEL_ALU = 2'b00,
    WBSEL_MEM = 2'b01,
    WBSEL_PC  = 2'b10
  } wbsel_e;

  localparam logic [4:0] REG_ZERO = 5'd0;
  localparam logic [4:0] REG_LINK = 5'd31;

endpackage

// File: rtl/regfile_2r1w.sv
// Register file with two combinational read ports (write-before-read bypass),
// one synchronous write port, synchronous clear and a hardwired zero register.
module regfile_2r1w
  import mips_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int NREGS = 32,
  parameter int AW    = $clog2(NREGS)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr_a,
  input  logic [AW-1:0]    raddr_b,
  output logic [WIDTH-1:0] rdata_a,
  output logic [WIDTH-1:0] rdata_b
);

  logic [WIDTH-1:0] regs [NREGS];
  logic [AW-1:0]    raddr [2];
  logic [WIDTH-1:0] rdata [2];

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NREGS; i++) regs[i] <= '0;
    end else if (we && waddr != AW'(REG_ZERO)) begin
      regs[waddr] <= wdata;
    end
  end

  assign raddr[0] = raddr_a;
  assign raddr[1] = raddr_b;

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_rport
      // Zero check first so $0 reads 0 even if storage were ever disturbed.
      always_comb begin
        if (raddr[gi] == AW'(REG_ZERO))
          rdata[gi] = '0;
        else if (we && raddr[gi] == waddr)
          rdata[gi] = wdata;
        else
          rdata[gi] = regs[raddr[gi]];
      end
    end
  endgenerate

  assign rdata_a = rdata[0];
  assign rdata_b = rdata[1];

endmodule

// File: rtl/wb_regfile_stage.sv
// Write-back stage: picks destination and data from the MEM/WB bundle, qualifies
// the commit, updates the register file and counts retired register writes.
module wb_regfile_stage
  import mips_pkg::*;
#(
  parameter int         WIDTH    = 32,
  parameter int         NREGS    = 32,
  parameter logic [4:0] LINK_REG = REG_LINK
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             holdreg,
  input  logic [4:0]       inst20to16,
  input  logic [4:0]       inst15to11,
  input  logic [WIDTH-1:0] readmemdata,
  input  logic [WIDTH-1:0] aluresult,
  input  logic [WIDTH-1:0] newpc,
  input  logic [4:0]       control_signals,
  input  logic [4:0]       rs_addr,
  input  logic [4:0]       rt_addr,
  output logic [WIDTH-1:0] RS_DATA,
  output logic [WIDTH-1:0] RT_DATA,
  output logic             WB_REGWRITE,
  output logic [4:0]       WB_ADDR,
  output logic [WIDTH-1:0] WB_DATA,
  output logic [31:0]      RETIRE_COUNT
);

  logic [1:0]       regdst;
  logic [1:0]       wbsel;
  logic             dst_legal;
  logic             src_legal;
  logic [4:0]       wb_addr;
  logic [WIDTH-1:0] wb_data;
  logic             wb_regwrite;
  logic [31:0]      retire_count_reg;

  assign regdst = control_signals[CTRL_REGDST_HI:CTRL_REGDST_LO];
  assign wbsel  = control_signals[CTRL_WBSEL_HI:CTRL_WBSEL_LO];

  always_comb begin
    dst_legal = 1'b1;
    wb_addr   = inst20to16;
    case (regdst)
      REGDST_RT:   wb_addr = inst20to16;
      REGDST_RD:   wb_addr = inst15to11;
      REGDST_LINK: wb_addr = LINK_REG;
      default:     dst_legal = 1'b0;
    endcase
  end

  always_comb begin
    src_legal = 1'b1;
    wb_data   = aluresult;
    case (wbsel)
      WBSEL_ALU: wb_data = aluresult;
      WBSEL_MEM: wb_data = readmemdata;
      WBSEL_PC:  wb_data = newpc;
      default:   src_legal = 1'b0;
    endcase
  end

  // Every disqualifier lands here, so storage, bypass and counter agree.
  assign wb_regwrite = control_signals[CTRL_REGWRITE] & ~holdreg & ~reset &
                       dst_legal & src_legal & (wb_addr != REG_ZERO);

  regfile_2r1w #(
    .WIDTH (WIDTH),
    .NREGS (NREGS),
    .AW    (5)
  ) u_regfile (
    .clk     (clk),
    .reset   (reset),
    .we      (wb_regwrite),
    .waddr   (wb_addr),
    .wdata   (wb_data),
    .raddr_a (rs_addr),
    .raddr_b (rt_addr),
    .rdata_a (RS_DATA),
    .rdata_b (RT_DATA)
  );

  always_ff @(posedge clk) begin
    if (reset)
      retire_count_reg <= '0;
    else if (wb_regwrite)
      retire_count_reg <= retire_count_reg + 32'd1;
  end

  assign WB_REGWRITE  = wb_regwrite;
  assign WB_ADDR      = wb_addr;
  assign WB_DATA      = wb_data;
  assign RETIRE_COUNT = retire_count_reg;

endmodule

// File: tb/tb_wb_regfile_stage.sv
// Scoreboard bench for wb_regfile_stage: a reference register model predicts
// each transaction's outputs, which are queued and compared as the DUT responds.
module tb_wb_regfile_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic        holdreg;
  logic [4:0]  inst20to16;
  logic [4:0]  inst15to11;
  logic [31:0] readmemdata;
  logic [31:0] aluresult;
  logic [31:0] newpc;
  logic [4:0]  control_signals;
  logic [4:0]  rs_addr;
  logic [4:0]  rt_addr;
  logic [31:0] RS_DATA;
  logic [31:0] RT_DATA;
  logic        WB_REGWRITE;
  logic [4:0]  WB_ADDR;
  logic [31:0] WB_DATA;
  logic [31:0] RETIRE_COUNT;

  always #5 clk = ~clk;

  wb_regfile_stage dut (
    .clk             (clk),
    .reset           (reset),
    .holdreg         (holdreg),
    .inst20to16      (inst20to16),
    .inst15to11      (inst15to11),
    .readmemdata     (readmemdata),
    .aluresult       (aluresult),
    .newpc           (newpc),
    .control_signals (control_signals),
    .rs_addr         (rs_addr),
    .rt_addr         (rt_addr),
    .RS_DATA         (RS_DATA),
    .RT_DATA         (RT_DATA),
    .WB_REGWRITE     (WB_REGWRITE),
    .WB_ADDR         (WB_ADDR),
    .WB_DATA         (WB_DATA),
    .RETIRE_COUNT    (RETIRE_COUNT)
  );

  typedef struct {
    logic        regwrite;
    logic [4:0]  addr;
    logic [31:0] data;
    logic [31:0] rs;
    logic [31:0] rt;
    logic [31:0] count;
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] mdl_regs [32];
  logic [31:0] mdl_count;
  int          tests_run = 0;
  int          failures  = 0;
  int          txn_no    = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Called at a negedge: drive one MEM/WB bundle, check the combinational
  // response, let one edge pass, then check the retire count.
  task automatic txn(input logic rst, input logic hold,
                     input logic [4:0] rt_f, input logic [4:0] rd_f,
                     input logic [31:0] mem, input logic [31:0] alu, input logic [31:0] pc,
                     input logic [4:0] ctrl, input logic [4:0] ra, input logic [4:0] rb);
    exp_t        e;
    exp_t        got;
    logic        legal;
    logic [4:0]  dst;
    logic [31:0] data;
    reset = rst; holdreg = hold; inst20to16 = rt_f; inst15to11 = rd_f;
    readmemdata = mem; aluresult = alu; newpc = pc; control_signals = ctrl;
    rs_addr = ra; rt_addr = rb;

    legal = 1'b1;
    dst   = rt_f;
    data  = alu;
    case (ctrl[4:3])
      2'b00: dst = rt_f;
      2'b01: dst = rd_f;
      2'b10: dst = 5'd31;
      default: legal = 1'b0;
    endcase
    case (ctrl[2:1])
      2'b00: data = alu;
      2'b01: data = mem;
      2'b10: data = pc;
      default: legal = 1'b0;
    endcase
    e.regwrite = ctrl[0] && !hold && !rst && legal && (dst != 5'd0);
    e.addr  = dst;
    e.data  = data;
    e.rs    = (ra == 5'd0) ? 32'd0 : (e.regwrite && ra == dst) ? data : mdl_regs[ra];
    e.rt    = (rb == 5'd0) ? 32'd0 : (e.regwrite && rb == dst) ? data : mdl_regs[rb];
    e.count = rst ? 32'd0 : (e.regwrite ? mdl_count + 32'd1 : mdl_count);
    exp_q.push_back(e);

    #1;
    got = exp_q.pop_front();
    check_val("wb_regwrite", {31'd0, WB_REGWRITE}, {31'd0, got.regwrite});
    if (got.regwrite) begin
      check_val("wb_addr", {27'd0, WB_ADDR}, {27'd0, got.addr});
      check_val("wb_data", WB_DATA, got.data);
    end
    check_val("rs_data", RS_DATA, got.rs);
    check_val("rt_data", RT_DATA, got.rt);

    @(posedge clk);
    if (rst) begin
      for (int i = 0; i < 32; i++) mdl_regs[i] = 32'd0;
    end else if (got.regwrite) begin
      mdl_regs[got.addr] = got.data;
    end
    mdl_count = got.count;

    @(negedge clk);
    check_val("retire_count", RETIRE_COUNT, got.count);
    txn_no++;
    $display("[TB] txn %0d rst=%0b hold=%0b ctrl=%05b we=%0b addr=%0d data=%08h count=%0d",
             txn_no, rst, hold, ctrl, got.regwrite, got.addr, got.data, got.count);
  endtask

  task automatic rd(input logic [4:0] ra, input logic [4:0] rb);
    txn(1'b0, 1'b0, 5'd0, 5'd0, 32'h0, 32'h0, 32'h0, 5'b00_00_0, ra, rb);
  endtask

  initial begin
    for (int i = 0; i < 32; i++) mdl_regs[i] = 32'd0;
    mdl_count = 32'd0;
    reset = 1'b1; holdreg = 1'b0; inst20to16 = '0; inst15to11 = '0;
    readmemdata = '0; aluresult = '0; newpc = '0; control_signals = '0;
    rs_addr = '0; rt_addr = '0;
    @(negedge clk);

    // Reset for two cycles, then every register reads back 0.
    txn(1'b1, 1'b0, 5'd0, 5'd0, 32'h0, 32'h0, 32'h0, 5'b00_00_0, 5'd0, 5'd1);
    txn(1'b1, 1'b0, 5'd0, 5'd0, 32'h0, 32'h0, 32'h0, 5'b00_00_0, 5'd2, 5'd3);
    for (int i = 0; i < 16; i++) rd(5'(2 * i), 5'(2 * i + 1));

    // R-type with same-cycle bypass, load, JAL, then plain readback.
    txn(1'b0, 1'b0, 5'd2, 5'd5, 32'h0, 32'h12345678, 32'h0, 5'b01_00_1, 5'd5, 5'd2);
    txn(1'b0, 1'b0, 5'd8, 5'd3, 32'hDEADBEEF, 32'h11111111, 32'h0, 5'b00_01_1, 5'd5, 5'd8);
    txn(1'b0, 1'b0, 5'd4, 5'd6, 32'h0, 32'h22222222, 32'h00400010, 5'b10_10_1, 5'd31, 5'd8);
    rd(5'd5, 5'd31);
    rd(5'd8, 5'd0);

    // Write to $0, reserved selects, RegWrite=0 with junk data.
    txn(1'b0, 1'b0, 5'd0, 5'd0, 32'h0, 32'hFFFFFFFF, 32'h0, 5'b01_00_1, 5'd0, 5'd0);
    txn(1'b0, 1'b0, 5'd6, 5'd6, 32'h0, 32'hAAAA5555, 32'h0, 5'b11_00_1, 5'd6, 5'd0);
    txn(1'b0, 1'b0, 5'd6, 5'd6, 32'h77777777, 32'hAAAA5555, 32'h0, 5'b00_11_1, 5'd6, 5'd0);
    txn(1'b0, 1'b0, 5'd6, 5'd6, 32'h77777777, 32'hAAAA5555, 32'h0, 5'b01_00_0, 5'd6, 5'd6);
    rd(5'd6, 5'd0);

    // Held write to $9 commits exactly once after the hold drops.
    for (int i = 0; i < 3; i++)
      txn(1'b0, 1'b1, 5'd1, 5'd9, 32'h0, 32'h99999999, 32'h0, 5'b01_00_1, 5'd9, 5'd9);
    txn(1'b0, 1'b0, 5'd1, 5'd9, 32'h0, 32'h99999999, 32'h0, 5'b01_00_1, 5'd9, 5'd9);
    rd(5'd9, 5'd5);

    // Both ports on the write target; overwrite with bypass on one port only.
    txn(1'b0, 1'b0, 5'd0, 5'd12, 32'h0, 32'hC0FFEE12, 32'h0, 5'b01_00_1, 5'd12, 5'd12);
    txn(1'b0, 1'b0, 5'd5, 5'd0, 32'h0, 32'h0BADF00D, 32'h0, 5'b00_00_1, 5'd8, 5'd5);
    rd(5'd5, 5'd12);

    // Random bundles against the model.
    for (int i = 0; i < 24; i++)
      txn(1'b0, ($urandom_range(0, 3) == 0), 5'($urandom), 5'($urandom), $urandom, $urandom,
          $urandom, 5'($urandom), 5'($urandom), 5'($urandom));

    // Reset collides with a write to $4; everything clears.
    txn(1'b1, 1'b0, 5'd0, 5'd4, 32'h0, 32'h44444444, 32'h0, 5'b01_00_1, 5'd4, 5'd5);
    rd(5'd4, 5'd5);
    rd(5'd9, 5'd31);

    // Counter wrap: preload to all-ones, then one commit.
    force dut.retire_count_reg = 32'hFFFFFFFF;
    #1;
    release dut.retire_count_reg;
    mdl_count = 32'hFFFFFFFF;
    check_val("count_preload", RETIRE_COUNT, 32'hFFFFFFFF);
    txn(1'b0, 1'b0, 5'd3, 5'd0, 32'h0, 32'h33333333, 32'h0, 5'b00_00_1, 5'd3, 5'd0);
    rd(5'd3, 5'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

endmodule
